// File: rtl/data_mem_hs_pkg.sv
// Shared types and sizing helpers for the handshaked data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Byte lanes per word.
  function automatic int lane_cnt(input int width);
    return width / 8;
  endfunction

  // Word-index width for a given depth.
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response valid-ready bus between the core load/store path and memory.
interface data_mem_hs_if
  import mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 32
);
  localparam int NB = lane_cnt(WIDTH);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NB-1:0]     req_be;
  logic [AWIDTH-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_hs_byte_ram.sv
// Word array with per-byte write enables, synchronous write, combinational read.
// Reusable as instruction memory; contents are never reset.
module byte_ram
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int NB   = lane_cnt(WIDTH),
  localparam int IW   = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [NB-1:0]    be,
  input  logic [IW-1:0]    idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Commit this byte lane only when its enable is set.
    always_ff @(posedge clk) begin
      if (we && be[l]) mem[idx] <= wdata[8*l +: 8];
    end

    assign rdata[8*l +: 8] = mem[idx];
  end

endmodule

// File: rtl/data_mem_hs.sv
// Valid/ready data memory: one outstanding access, WAIT_STATES extra cycles,
// byte-lane stores, misaligned/out-of-range error reporting.
module data_mem_hs
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1,
  parameter int AWIDTH      = 32
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_hs_if.slave  bus
);

  localparam int NB = lane_cnt(WIDTH);
  localparam int LW = $clog2(NB);
  localparam int IW = idx_w(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [AWIDTH-1:0] LANE_MASK = AWIDTH'(NB - 1);

  mem_state_t        state, state_d;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [NB-1:0]     lat_be;
  logic [AWIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic [WIDTH-1:0]  rdata_q;
  logic              err_q;

  logic              acc_we;
  logic [NB-1:0]     acc_be;
  logic [AWIDTH-1:0] acc_addr;
  logic [WIDTH-1:0]  acc_wdata;
  logic              acc_err;
  logic              commit;
  logic              ram_we;
  logic [WIDTH-1:0]  ram_rdata;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state: accept in IDLE, count down in WAIT, hold RESP until consumed.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.req_valid) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the array is touched on the accept edge itself, so
  // the live request is used in IDLE and the latched copy otherwise.
  always_comb begin
    acc_we    = lat_we;
    acc_be    = lat_be;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_be    = bus.req_be;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end
    acc_err = (|(acc_addr & LANE_MASK)) || (|(acc_addr >> (IW + LW)));
    commit  = (state == IDLE && WAIT_STATES == 0 && bus.req_valid) ||
              (state == WAIT && cnt == 4'd0);
  end

  // Gating with rst keeps a store from landing while reset is held.
  assign ram_we = commit && acc_we && !acc_err && rst;

  byte_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (acc_be),
    .idx   (acc_addr[IW+LW-1:LW]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // State, wait counter, request latch and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.req_valid) begin
        lat_we    <= bus.req_we;
        lat_be    <= bus.req_be;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata_q <= (!acc_we && !acc_err) ? ram_rdata : '0;
        err_q   <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench: two instances (1 and 0 wait states) with a response scoreboard.
module tb_data_mem_hs;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_hs_if #(.WIDTH(32), .AWIDTH(32)) bus1 ();
  data_mem_hs_if #(.WIDTH(32), .AWIDTH(32)) bus0 ();

  data_mem_hs #(.WIDTH(32), .DEPTH(64), .WAIT_STATES(1), .AWIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  data_mem_hs #(.WIDTH(32), .DEPTH(64), .WAIT_STATES(0), .AWIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  logic        t_we = 1'b0;
  logic [3:0]  t_be = 4'h0;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_wdata = 32'h0;
  logic        v1 = 1'b0, v0 = 1'b0, r1 = 1'b0, r0 = 1'b0;
  logic        use0 = 1'b0;

  assign bus1.req_we = t_we;   assign bus0.req_we = t_we;
  assign bus1.req_be = t_be;   assign bus0.req_be = t_be;
  assign bus1.req_addr = t_addr; assign bus0.req_addr = t_addr;
  assign bus1.req_wdata = t_wdata; assign bus0.req_wdata = t_wdata;
  assign bus1.req_valid = v1;  assign bus0.req_valid = v0;
  assign bus1.rsp_ready = r1;  assign bus0.rsp_ready = r0;

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;
  assign o_ready = use0 ? bus0.req_ready : bus1.req_ready;
  assign o_valid = use0 ? bus0.rsp_valid : bus1.rsp_valid;
  assign o_err   = use0 ? bus0.rsp_err   : bus1.rsp_err;
  assign o_rdata = use0 ? bus0.rsp_rdata : bus1.rsp_rdata;

  rsp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access on the selected instance; hold = cycles of rsp back-pressure.
  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                        input int exp_lat, input int hold, input string tag);
    rsp_t e;
    int lat;
    @(negedge clk);
    t_we = we; t_addr = addr; t_be = be; t_wdata = wdata;
    if (use0) v0 = 1'b1; else v1 = 1'b1;
    e.rdata = erd; e.err = eerr;
    sb.push_back(e);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 20);
    check({tag, ":latency"}, lat, exp_lat);
    e = sb.pop_front();
    check({tag, ":rdata"}, o_rdata, e.rdata);
    check({tag, ":err"}, {31'd0, o_err}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, ":hold_ready"}, {31'd0, o_ready}, 32'd0);
      check({tag, ":hold_rdata"}, o_rdata, e.rdata);
      check({tag, ":hold_err"}, {31'd0, o_err}, {31'd0, e.err});
    end
    if (use0) r0 = 1'b1; else r1 = 1'b1;
    @(posedge clk); #1;
    r0 = 1'b0; r1 = 1'b0;
    @(negedge clk);
    check({tag, ":idle_ready"}, {31'd0, o_ready}, 32'd1);
    check({tag, ":idle_valid"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst:req_ready", {31'd0, bus1.req_ready}, 32'd1);
    check("rst:rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("rst:rsp_rdata", bus1.rsp_rdata, 32'd0);
    check("rst:rsp_err", {31'd0, bus1.rsp_err}, 32'd0);
    check("rst:req_ready0", {31'd0, bus0.req_ready}, 32'd1);

    // Store/load round trip.
    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, "st10");
    access(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "ld10");

    // Byte lanes.
    access(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 2, 0, "st20");
    access(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, 2, 0, "st20be");
    access(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, 2, 0, "ld20");

    // Empty byte-enable store is a legal no-op.
    access(1'b1, 32'h10, 4'h0, 32'h12345678, 32'h0, 1'b0, 2, 0, "stbe0");
    access(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "ld10b");

    // Errors and range boundary.
    access(1'b0, 32'h13, 4'h0, 32'h0, 32'h0, 1'b1, 2, 0, "ldmis");
    access(1'b1, 32'h0, 4'hF, 32'h01020304, 32'h0, 1'b0, 2, 0, "st0");
    access(1'b1, 32'h100, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1, 2, 0, "stoor");
    access(1'b0, 32'h0, 4'h0, 32'h0, 32'h01020304, 1'b0, 2, 0, "ld0");
    access(1'b1, 32'hFC, 4'hF, 32'h0BADCAFE, 32'h0, 1'b0, 2, 0, "stlast");
    access(1'b0, 32'hFC, 4'h0, 32'h0, 32'h0BADCAFE, 1'b0, 2, 0, "ldlast");
    access(1'b0, 32'h8000_0010, 4'h0, 32'h0, 32'h0, 1'b1, 2, 0, "ldhigh");

    // Back-pressure in RESP.
    access(1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 2, 4, "bp");

    // Reset during WAIT of a store aborts it.
    access(1'b1, 32'h30, 4'hF, 32'h55667788, 32'h0, 1'b0, 2, 0, "st30");
    @(negedge clk);
    t_we = 1'b1; t_addr = 32'h30; t_be = 4'hF; t_wdata = 32'hFFFFFFFF; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort:req_ready", {31'd0, bus1.req_ready}, 32'd1);
    check("abort:rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    check("abort:rsp_rdata", bus1.rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b0, 32'h30, 4'h0, 32'h0, 32'h55667788, 1'b0, 2, 0, "ld30");

    // Zero wait states.
    use0 = 1'b1;
    access(1'b1, 32'h40, 4'hF, 32'hA5A55A5A, 32'h0, 1'b0, 1, 0, "ws0st");
    access(1'b0, 32'h40, 4'h0, 32'h0, 32'hA5A55A5A, 1'b0, 1, 0, "ws0ld");
    access(1'b0, 32'h42, 4'h0, 32'h0, 32'h0, 1'b1, 1, 2, "ws0mis");

    check("sb:empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
